// File: rtl/avl_bus_slave_ram.sv
// Word-addressed RAM slave for the Avalon-style bus: byte-enable writes, single and burst
// reads, and a small in-order response FIFO that honours resp_ready back-pressure.
module avl_bus_slave_ram #(
   parameter int ADDR_WIDTH      = 10,
   parameter int RESP_FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rest,
   input  logic [31:0] avl_s_address,
   input  logic [3:0]  avl_s_byte_en,
   input  logic        avl_s_read,
   input  logic        avl_s_write,
   input  logic [31:0] avl_s_write_data,
   input  logic        avl_s_begin_burst_transfer,
   input  logic [7:0]  avl_s_burst_count,
   output logic        avl_s_request_ready,
   output logic [31:0] avl_s_read_data,
   output logic        avl_s_read_data_valid,
   input  logic        avl_s_resp_ready
);

   localparam int RAM_DEPTH = 2 ** ADDR_WIDTH;
   localparam int PW        = $clog2(RESP_FIFO_DEPTH);
   localparam int CW        = PW + 1;
   localparam logic [CW-1:0] FIFO_FULL = CW'(RESP_FIFO_DEPTH);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_q, state_d;
   logic [7:0]            remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  req_ready_q, req_ready_d;

   logic [31:0]           ram_q  [RAM_DEPTH];
   logic [31:0]           fifo_q [RESP_FIFO_DEPTH];

   logic [ADDR_WIDTH-1:0] word;
   logic [ADDR_WIDTH-1:0] push_addr;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic                  ram_we;
   logic                  unused_addr_bits;

   assign word             = avl_s_address[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^{avl_s_address[31:ADDR_WIDTH+2], avl_s_address[1:0]};
   assign accept           = (avl_s_read || avl_s_write) && req_ready_q;

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      next_addr_d = next_addr_q;
      push        = 1'b0;
      push_addr   = word;
      ram_we      = 1'b0;
      pop         = (count_q != '0) && avl_s_resp_ready;
      case (state_q)
         IDLE: begin
            // A simultaneous read and write is served as a read; the write is dropped.
            if (accept && avl_s_read) begin
               push = 1'b1;
               if (avl_s_begin_burst_transfer && (avl_s_burst_count >= 8'd2)) begin
                  state_d     = BURST;
                  remaining_d = avl_s_burst_count - 8'd1;
                  next_addr_d = word + ADDR_WIDTH'(1);
               end
            end else if (accept) begin
               ram_we = 1'b1;
            end
         end
         BURST: begin
            if ((count_q < FIFO_FULL) || pop) begin
               push        = 1'b1;
               push_addr   = next_addr_q;
               next_addr_d = next_addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - 8'd1;
               if (remaining_q == 8'd1) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      count_d     = count_q + CW'(push) - CW'(pop);
      wr_ptr_d    = wr_ptr_q + PW'(push);
      rd_ptr_d    = rd_ptr_q + PW'(pop);
      req_ready_d = (state_d == IDLE) && (count_d < FIFO_FULL);
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         next_addr_q <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         req_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         next_addr_q <= next_addr_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         req_ready_q <= req_ready_d;
      end
   end

   // Storage arrays carry no reset; the RAM keeps its contents across rest.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int i = 0; i < 4; i++) begin
            if (avl_s_byte_en[i]) begin
               ram_q[word][8*i +: 8] <= avl_s_write_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= ram_q[push_addr];
      end
   end

   assign avl_s_request_ready   = req_ready_q;
   assign avl_s_read_data_valid = (count_q != '0);
   assign avl_s_read_data       = (count_q != '0) ? fifo_q[rd_ptr_q] : 32'h0;

   a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rest)
      push |-> ((count_q < FIFO_FULL) || pop));

endmodule

// File: tb/tb_avl_bus_slave_ram.sv
// Randomized bench for avl_bus_slave_ram against a word-array memory model and an
// expected-response queue.
module tb_avl_bus_slave_ram;

   localparam int AW    = 10;
   localparam int DEPTH = 4;
   localparam int WORDS = 1 << AW;

   logic        clk = 1'b0;
   logic        rest;
   logic [31:0] address;
   logic [3:0]  byte_en;
   logic        read;
   logic        write;
   logic [31:0] write_data;
   logic        begin_burst;
   logic [7:0]  burst_count;
   logic        request_ready;
   logic [31:0] read_data;
   logic        read_data_valid;
   logic        resp_ready;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] ref_mem [WORDS];
   logic [31:0] exp_q [$];
   logic        rr_rand  = 1'b0;
   logic        rr_force = 1'b0;

   avl_bus_slave_ram #(.ADDR_WIDTH(AW), .RESP_FIFO_DEPTH(DEPTH)) dut (
      .clk                        (clk),
      .rest                       (rest),
      .avl_s_address              (address),
      .avl_s_byte_en              (byte_en),
      .avl_s_read                 (read),
      .avl_s_write                (write),
      .avl_s_write_data           (write_data),
      .avl_s_begin_burst_transfer (begin_burst),
      .avl_s_burst_count          (burst_count),
      .avl_s_request_ready        (request_ready),
      .avl_s_read_data            (read_data),
      .avl_s_read_data_valid      (read_data_valid),
      .avl_s_resp_ready           (resp_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (rr_rand) resp_ready = 1'($urandom_range(0, 1));
      else         resp_ready = rr_force;
   end

   // Response monitor: every beat the master takes must match the oldest expected entry.
   always @(negedge clk) begin
      if (rest) begin
         if (read_data_valid) begin
            if (exp_q.size() == 0) begin
               chk("stale_beat", {31'b0, read_data_valid}, 32'h0);
            end else if (resp_ready) begin
               chk("resp", read_data, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               chk("head_hold", read_data, exp_q[0]);
            end
         end else begin
            chk("empty_data", read_data, 32'h0);
         end
      end
   end

   task automatic model_accept(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] data,
                               input logic bst, input logic [7:0] cnt);
      int w;
      w = int'(addr >> 2) % WORDS;
      if (rd) begin
         if (bst && cnt >= 2) begin
            for (int i = 0; i < int'(cnt); i++) exp_q.push_back(ref_mem[(w + i) % WORDS]);
         end else begin
            exp_q.push_back(ref_mem[w]);
         end
      end else if (wr) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) ref_mem[w][8*i +: 8] = data[8*i +: 8];
      end
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] data,
                         input logic bst, input logic [7:0] cnt);
      int waitc;
      waitc       = 0;
      address     = addr;
      byte_en     = be;
      write_data  = data;
      begin_burst = bst;
      burst_count = cnt;
      read        = rd;
      write       = wr;
      @(negedge clk);
      while (!request_ready && waitc < 500) begin
         @(negedge clk);
         waitc++;
      end
      if (!request_ready) begin
         chk("req_timeout", {31'b0, request_ready}, 32'h1);
         read  = 1'b0;
         write = 1'b0;
         return;
      end
      @(posedge clk);
      model_accept(rd, wr, addr, be, data, bst, cnt);
      #1;
      read  = 1'b0;
      write = 1'b0;
   endtask

   task automatic wr_word(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      do_req(1'b0, 1'b1, addr, be, data, 1'b0, 8'd0);
   endtask

   task automatic rd_word(input logic [31:0] addr);
      do_req(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b0, 8'd0);
   endtask

   task automatic drain();
      int waitc;
      waitc = 0;
      while ((exp_q.size() != 0 || read_data_valid) && waitc < 2000) begin
         @(negedge clk);
         waitc++;
      end
      chk("drain_timeout", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic set_rr(input logic rnd, input logic force_val);
      rr_rand  = rnd;
      rr_force = force_val;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rest        = 1'b0;
      address     = '0;
      byte_en     = '0;
      read        = 1'b0;
      write       = 1'b0;
      write_data  = '0;
      begin_burst = 1'b0;
      burst_count = '0;
      resp_ready  = 1'b0;
      for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;

      // Reset state and release behaviour.
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, request_ready}, 32'h0);
      chk("rst_valid", {31'b0, read_data_valid}, 32'h0);
      chk("rst_data", read_data, 32'h0);
      rest = 1'b1;
      #1;
      chk("rel_ready_low", {31'b0, request_ready}, 32'h0);
      @(negedge clk);
      chk("rel_ready_high", {31'b0, request_ready}, 32'h1);

      // Test 1: write then single read, one-cycle latency, single pulse.
      set_rr(1'b0, 1'b1);
      wr_word(32'h10, 32'hDEADBEEF, 4'hF);
      rd_word(32'h10);
      @(negedge clk);
      chk("t1_valid", {31'b0, read_data_valid}, 32'h1);
      chk("t1_data", read_data, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_pulse", {31'b0, read_data_valid}, 32'h0);

      // Test 2: byte lanes.
      @(posedge clk); #1;
      wr_word(32'h20, 32'h11223344, 4'b1111);
      wr_word(32'h20, 32'hAABBCCDD, 4'b0001);
      wr_word(32'h20, 32'h55667788, 4'b0011);
      rd_word(32'h20);
      @(negedge clk);
      chk("t2_lanes", read_data, 32'h11227788);
      drain();

      // Fill the whole RAM so every later read has defined contents.
      @(posedge clk); #1;
      for (int i = 0; i < WORDS; i++) wr_word(32'(i * 4), $urandom, 4'hF);

      // Test 3: back-pressure with four queued responses, fifth waits.
      set_rr(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) rd_word(32'((100 + i) * 4));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t3_full_ready", {31'b0, request_ready}, 32'h0);
      end
      @(posedge clk); #1;
      rr_force = 1'b1;
      rd_word(32'(104 * 4));
      drain();

      // Test 4: burst of four from word 2 with random back-pressure.
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) wr_word(32'(i * 4), 32'h100 + 32'(i), 4'hF);
      set_rr(1'b1, 1'b0);
      do_req(1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 1'b1, 8'd4);
      @(negedge clk);
      chk("t4_busy_ready", {31'b0, request_ready}, 32'h0);
      drain();

      // Test 5: burst wrap past the top of the RAM and address aliasing.
      @(posedge clk); #1;
      do_req(1'b1, 1'b0, 32'(1022 * 4), 4'h0, 32'h0, 1'b1, 8'd4);
      drain();
      set_rr(1'b0, 1'b1);
      wr_word(32'h1000, 32'hCAFE0001, 4'hF);
      rd_word(32'h0);
      @(negedge clk);
      chk("t5_alias", read_data, 32'hCAFE0001);
      drain();

      // Test 6: async reset mid-burst with three entries held.
      set_rr(1'b0, 1'b0);
      do_req(1'b1, 1'b0, 32'(10 * 4), 4'h0, 32'h0, 1'b1, 8'd8);
      @(posedge clk);
      @(posedge clk);
      #2;
      rest = 1'b0;
      #1;
      chk("t6_valid", {31'b0, read_data_valid}, 32'h0);
      chk("t6_ready", {31'b0, request_ready}, 32'h0);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rest = 1'b1;
      @(posedge clk); #1;
      rr_force = 1'b1;
      rd_word(32'(10 * 4));
      drain();
      repeat (4) @(negedge clk);

      // Test 7: random soak.
      set_rr(1'b1, 1'b0);
      for (int n = 0; n < 10000; n++) begin
         int   kind;
         logic rd;
         logic wr;
         kind = $urandom_range(0, 99);
         rd   = (kind < 45) || (kind >= 90);
         wr   = (kind >= 45);
         do_req(rd, wr, $urandom, 4'($urandom), $urandom,
                ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 6)));
      end
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/avl_bus_slave_ram.md
Name: avl_bus_slave_ram

Overview:
Synthesizable responder for the i_avl_bus protocol: a word-addressed on-chip RAM slave with byte-enable writes, single and burst reads, and a response FIFO that honours master back-pressure on resp_ready.
It sits on a slave port of the bus interconnect and serves as the default memory target in bus-level benches driven by the random bus-master model.

Parameters:
ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH 32-bit words.
RESP_FIFO_DEPTH, 4, read-response FIFO entries; power of two, minimum 2.

Ports:
clk  input  1  system clock, all state on rising edge.
rest  input  1  asynchronous active-low reset.
avl_s  modport  -  i_avl_bus.slave; fields used below.
avl_s.address  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word.
avl_s.byte_en  input  4  write byte lanes.
avl_s.read  input  1  read request.
avl_s.write  input  1  write request.
avl_s.write_data  input  32  write data.
avl_s.begin_burst_transfer  input  1  marks a burst read request.
avl_s.burst_count  input  8  burst length in words.
avl_s.request_ready  output  1  slave can accept a request this cycle.
avl_s.read_data  output  32  FIFO head data.
avl_s.read_data_valid  output  1  FIFO non-empty.
avl_s.resp_ready  input  1  master accepts the response at the head.

Behaviour:
- Reset (rest low, async): FIFO emptied, read_data=0, read_data_valid=0, request_ready=0, FSM=IDLE, burst counter/address=0. The RAM array is not reset; contents are undefined until written. request_ready rises on the first clk edge after rest deasserts.
- Accept: a request is accepted on a rising edge with (read||write)&&request_ready.
- request_ready is registered: high iff FSM=IDLE and FIFO count after this edge is < RESP_FIFO_DEPTH. It is never combinationally dependent on resp_ready.
- read&&write together: the access is treated as a read, and the write is dropped.
- Address handling: bits [1:0] and bits above ADDR_WIDTH+1 are ignored, so higher addresses alias.
- Write: on the accept edge, for each lane i with byte_en[i]=1, mem[word][8i+7:8i] <= write_data lane i. A write produces no response. begin_burst_transfer is ignored on writes; each beat is an independent write.
- Single read (begin_burst_transfer=0, or burst_count<=1): on the accept edge, mem[word] is pushed into the FIFO. read_data_valid is asserted at the earliest in the cycle after acceptance (latency 1).
- Read-after-write: a read accepted in the cycle after a write to the same word returns the new data.
- FSM IDLE -> BURST: entered on accepting a read with begin_burst_transfer=1 and burst_count>=2.
  - On the accept edge, word addr is pushed, remaining is set to burst_count-1, and next addr is set to addr+1 (wrapping modulo RAM depth).
- FSM BURST: on each edge where the FIFO has space (count<DEPTH, counting a same-edge pop), mem[next] is pushed, next is incremented, and remaining is decremented.
  - When remaining reaches 0, the FSM returns to IDLE.
  - request_ready=0 throughout BURST.
- FIFO pop: on an edge with read_data_valid&&resp_ready. Push and pop on the same edge keeps the count unchanged.
  - A push into a full FIFO is impossible by construction; assert this in simulation.
- read_data holds the head value while read_data_valid=1 and resp_ready=0. read_data is 0 when the FIFO is empty.
- Responses are returned strictly in acceptance order, including burst beats.
- Reset mid-burst: the burst is abandoned, the FIFO is cleared, and the RAM keeps any completed writes.

Test Plan:
1. Reset, write 0x0000_0010 data 0xDEADBEEF byte_en 4'b1111, then read 0x10 with resp_ready=1 -> read_data_valid exactly 1 cycle after acceptance, read_data=0xDEADBEEF, single pulse.
2. Byte lanes: write 0x11223344 at 0x20 with en 1111, then 0xAABBCCDD with en 0001, then 0x55667788 with en 0011, then read 0x20 -> 0x11227788.
3. Back-pressure: resp_ready=0, issue 5 reads of distinct preloaded words -> request_ready low after the 4th acceptance, 5th waits. Raise resp_ready -> 5 responses in issue order, with no loss or duplication.
4. Burst: preload words 0..7 with values 0x100+i, then burst read at 0x8 with count 4 and resp_ready toggling randomly -> responses 0x102,0x103,0x104,0x105 in order, request_ready=0 until the last beat is queued.
5. Wrap and alias: with ADDR_WIDTH=10, burst read at word 1022 with count 4 -> words 1022,1023,0,1. A write to address 0x1000 modifies word 0.
6. Async reset mid-burst while the FIFO holds 3 entries -> read_data_valid=0 and request_ready=0 immediately. After release, a fresh single read returns correct data and no stale beats appear.
7. Random soak: random-master traffic against a reference memory model, 10k transactions, zero mismatches.
